i2s_tx_serializer: RTL

- Output end of the audio chain: accepts signed 16-bit mono samples from the preprocessor output over a valid/ready handshake.
- Serializes each sample as a Philips I2S frame (left slot, then right slot, same sample in both) for an external DAC.
- Generates BCLK and LRCLK from the system clock. Sits directly after the echo stage at the chip boundary.

---
 rtl/i2s_tx_serializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: takes mono samples over valid/ready and plays each one
// in both the left and right slots. BCLK and LRCLK are derived from clk.
module i2s_tx_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_BITS = 2 * SAMPLE_W;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_next;
  logic [BIT_W-1:0]    slot_idx;
  logic [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0] frame_reg;
  logic [SAMPLE_W-1:0] shift_src;
  logic [SAMPLE_W-1:0] shifted;
  logic                hold_full;
  logic                div_wrap;
  logic                shift_evt;
  logic                load_evt;
  logic                take;
  logic                sdata_next;
  logic                lrclk_next;

  // On the frame's first shift the MSB comes straight from the value being loaded.
  always_comb begin
    div_wrap     = (div_cnt == DIV_LAST);
    shift_evt    = en && div_wrap && bclk;
    bit_next     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    load_evt     = shift_evt && (bit_next == '0);
    slot_idx     = (bit_next >= BIT_W'(SAMPLE_W)) ? bit_next - BIT_W'(SAMPLE_W) : bit_next;
    shift_src    = load_evt ? (hold_full ? hold : '0) : frame_reg;
    shifted      = shift_src << slot_idx;
    sdata_next   = shifted[SAMPLE_W-1];
    lrclk_next   = (bit_next >= BIT_W'(SAMPLE_W - 1)) && (bit_next <= BIT_W'(FRAME_BITS - 2));
    take         = sample_valid && !hold_full;
    sample_ready = !hold_full;
    frame_start  = load_evt;
    underrun     = load_evt && !hold_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= BIT_LAST;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= BIT_LAST;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (shift_evt) begin
        bit_cnt <= bit_next;
        lrclk   <= lrclk_next;
        sdata   <= sdata_next;
      end
    end
  end

  // A load and a transfer on the same edge: the load sees the pre-transfer hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      frame_reg <= '0;
    end else begin
      if (load_evt) begin
        frame_reg <= shift_src;
      end
      if (take) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end else if (load_evt) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
